// File: rtl/sa_write_addr_gen.sv
// Write-address generator for systolic-array output tiles into banked BRAM.
// Walks rows within a tile by a row stride and tiles by a tile step using
// accumulators only. Each accepted beat issues one registered write to all
// enabled banks. Running past the legal BRAM depth aborts the job with a
// sticky error.
module sa_write_addr_gen #(
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 9,
    parameter int MAX_DEPTH  = 36864
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [ADDR_WIDTH-1:0] cfg_row_stride,
    input  logic [ADDR_WIDTH-1:0] cfg_tile_step,
    input  logic [CNT_WIDTH-1:0]  cfg_rows,
    input  logic [CNT_WIDTH-1:0]  cfg_tiles,
    input  logic [NUM_BANKS-1:0]  cfg_bank_mask,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [NUM_BANKS-1:0]  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    // Pointers carry one extra bit so a wrap past 2^ADDR_WIDTH is visible.
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_LIM = PW'(MAX_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         row_ptr_q, row_ptr_d;
    logic [PW-1:0]         tile_ptr_q, tile_ptr_d;
    logic [CNT_WIDTH-1:0]  row_cnt_q, row_cnt_d;
    logic [CNT_WIDTH-1:0]  tile_cnt_q, tile_cnt_d;
    logic [CNT_WIDTH-1:0]  rows_last_q, rows_last_d;
    logic [CNT_WIDTH-1:0]  tiles_last_q, tiles_last_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [ADDR_WIDTH-1:0] step_q, step_d;
    logic [NUM_BANKS-1:0]  mask_q, mask_d;
    logic                  err_q, err_d;
    logic [NUM_BANKS-1:0]  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic          illegal;
    logic          beat;
    logic          last_row;
    logic          last_tile;
    logic [PW-1:0] next_tile_ptr;

    // Datapath status: legality of the current address and the handshake.
    always_comb begin
        illegal       = (state_q == S_RUN) &&
                        (row_ptr_q[ADDR_WIDTH] || (row_ptr_q >= DEPTH_LIM));
        in_ready      = (state_q == S_RUN) && !illegal && !abort;
        beat          = in_valid && in_ready;
        last_row      = (row_cnt_q == rows_last_q);
        last_tile     = (tile_cnt_q == tiles_last_q);
        next_tile_ptr = tile_ptr_q + {1'b0, step_q};
    end

    // Next-state logic: job control, address accumulation and write issue.
    always_comb begin
        state_d      = state_q;
        row_ptr_d    = row_ptr_q;
        tile_ptr_d   = tile_ptr_q;
        row_cnt_d    = row_cnt_q;
        tile_cnt_d   = tile_cnt_q;
        rows_last_d  = rows_last_q;
        tiles_last_d = tiles_last_q;
        stride_d     = stride_q;
        step_d       = step_q;
        mask_d       = mask_q;
        err_d        = err_q;
        we_d         = '0;
        addr_d       = addr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_RUN;
                    row_ptr_d    = {1'b0, cfg_base};
                    tile_ptr_d   = {1'b0, cfg_base};
                    row_cnt_d    = '0;
                    tile_cnt_d   = '0;
                    // A zero count means one row/tile, so the terminal index is 0.
                    rows_last_d  = (cfg_rows == '0)  ? '0 : cfg_rows - CNT_WIDTH'(1);
                    tiles_last_d = (cfg_tiles == '0) ? '0 : cfg_tiles - CNT_WIDTH'(1);
                    stride_d     = cfg_row_stride;
                    step_d       = cfg_tile_step;
                    mask_d       = cfg_bank_mask;
                    err_d        = 1'b0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_DONE;
                end else if (illegal) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (beat) begin
                    we_d   = mask_q;
                    addr_d = row_ptr_q[ADDR_WIDTH-1:0];
                    if (last_row) begin
                        if (last_tile) begin
                            state_d = S_DONE;
                        end else begin
                            row_cnt_d  = '0;
                            tile_cnt_d = tile_cnt_q + CNT_WIDTH'(1);
                            tile_ptr_d = next_tile_ptr;
                            row_ptr_d  = next_tile_ptr;
                        end
                    end else begin
                        row_cnt_d = row_cnt_q + CNT_WIDTH'(1);
                        row_ptr_d = row_ptr_q + {1'b0, stride_q};
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, configuration and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            row_ptr_q    <= '0;
            tile_ptr_q   <= '0;
            row_cnt_q    <= '0;
            tile_cnt_q   <= '0;
            rows_last_q  <= '0;
            tiles_last_q <= '0;
            stride_q     <= '0;
            step_q       <= '0;
            mask_q       <= '0;
            err_q        <= 1'b0;
            we_q         <= '0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            row_ptr_q    <= row_ptr_d;
            tile_ptr_q   <= tile_ptr_d;
            row_cnt_q    <= row_cnt_d;
            tile_cnt_q   <= tile_cnt_d;
            rows_last_q  <= rows_last_d;
            tiles_last_q <= tiles_last_d;
            stride_q     <= stride_d;
            step_q       <= step_d;
            mask_q       <= mask_d;
            err_q        <= err_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        bram_we   = we_q;
        bram_addr = addr_q;
        busy      = (state_q == S_RUN);
        done      = (state_q == S_DONE);
        err       = err_q;
    end

endmodule

// File: tb/tb_sa_write_addr_gen.sv
// Bench for sa_write_addr_gen: a job-level model (address list computed by
// multiplication) is checked against the DUT every cycle, plus hand-computed
// expectations per directed test.
module tb_sa_write_addr_gen;

    localparam int NB = 4;
    localparam int AW = 16;
    localparam int CW = 9;
    localparam int MD = 36864;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] cfg_base = '0;
    logic [AW-1:0] cfg_row_stride = '0;
    logic [AW-1:0] cfg_tile_step = '0;
    logic [CW-1:0] cfg_rows = '0;
    logic [CW-1:0] cfg_tiles = '0;
    logic [NB-1:0] cfg_bank_mask = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NB-1:0] bram_we;
    logic [AW-1:0] bram_addr;
    logic          busy;
    logic          done;
    logic          err;

    sa_write_addr_gen #(
        .NUM_BANKS (NB),
        .ADDR_WIDTH(AW),
        .CNT_WIDTH (CW),
        .MAX_DEPTH (MD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .cfg_base      (cfg_base),
        .cfg_row_stride(cfg_row_stride),
        .cfg_tile_step (cfg_tile_step),
        .cfg_rows      (cfg_rows),
        .cfg_tiles     (cfg_tiles),
        .cfg_bank_mask (cfg_bank_mask),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .bram_we       (bram_we),
        .bram_addr     (bram_addr),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- job-level model ----------------
    int m_phase = 0;          // 0 idle, 1 running, 2 done pulse
    int m_addrs[$];           // legal addresses the job will write, in order
    int m_total = 0;          // rows*tiles
    int m_idx = 0;            // beats accepted so far
    int m_mask = 0;
    int m_err = 0;
    int exp_we = 0;
    int exp_addr = 0;

    // observation log filled by the monitor
    int wlog[$];
    int wmask_last = 0;
    int n_done = 0;
    int cyc = 0;
    int first_we_cyc = 0;
    int done_cyc = 0;

    function automatic int wget(input int i);
        if (i < wlog.size()) return wlog[i];
        return -1;
    endfunction

    // Compare the DUT against the model, then advance the model one clock.
    always @(negedge clk) begin
        int ready;
        int rows;
        int tiles;
        cyc++;
        if (!rst_n) begin
            m_phase = 0; m_idx = 0; m_err = 0; exp_we = 0; exp_addr = 0;
            m_addrs.delete();
            chk("rst_in_ready", int'(in_ready), 0);
            chk("rst_we", int'(bram_we), 0);
            chk("rst_addr", int'(bram_addr), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_err", int'(err), 0);
        end else begin
            ready = (m_phase == 1 && !abort && m_idx < m_addrs.size()) ? 1 : 0;
            chk("in_ready", int'(in_ready), ready);
            chk("busy", int'(busy), (m_phase == 1) ? 1 : 0);
            chk("done", int'(done), (m_phase == 2) ? 1 : 0);
            chk("err", int'(err), m_err);
            chk("bram_we", int'(bram_we), exp_we);
            chk("bram_addr", int'(bram_addr), exp_addr);

            if (bram_we != '0) begin
                if (wlog.size() == 0) first_we_cyc = cyc;
                wlog.push_back(int'(bram_addr));
                wmask_last = int'(bram_we);
                $display("write addr=%0d we=%b cyc=%0d", bram_addr, bram_we, cyc);
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                $display("done err=%0d cyc=%0d", err, cyc);
            end

            exp_we = 0;
            case (m_phase)
                0: if (start) begin
                    rows  = (cfg_rows == '0) ? 1 : int'(cfg_rows);
                    tiles = (cfg_tiles == '0) ? 1 : int'(cfg_tiles);
                    m_total = rows * tiles;
                    m_addrs.delete();
                    begin : build
                        for (int t = 0; t < tiles; t++)
                            for (int r = 0; r < rows; r++) begin
                                int a;
                                a = int'(cfg_base) + t * int'(cfg_tile_step) + r * int'(cfg_row_stride);
                                if (a >= MD) disable build;
                                m_addrs.push_back(a);
                            end
                    end
                    m_mask  = int'(cfg_bank_mask);
                    m_idx   = 0;
                    m_err   = 0;
                    m_phase = 1;
                end
                1: begin
                    if (abort) begin
                        m_phase = 2;
                    end else if (m_idx >= m_addrs.size()) begin
                        m_err   = 1;
                        m_phase = 2;
                    end else if (in_valid) begin
                        exp_we   = m_mask;
                        exp_addr = m_addrs[m_idx];
                        m_idx++;
                        if (m_idx == m_total) m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int base, input int stride, input int tstep,
                             input int rows, input int tiles, input int mask);
        cfg_base       = AW'(base);
        cfg_row_stride = AW'(stride);
        cfg_tile_step  = AW'(tstep);
        cfg_rows       = CW'(rows);
        cfg_tiles      = CW'(tiles);
        cfg_bank_mask  = NB'(mask);
        start = 1'b1;
        step();
        start = 1'b0;
        // scramble cfg: the latched job must be unaffected
        cfg_base       = 16'h1234;
        cfg_row_stride = 16'd7;
        cfg_tile_step  = 16'd3;
        cfg_rows       = 9'd5;
        cfg_tiles      = 9'd9;
        cfg_bank_mask  = 4'b1010;
    endtask

    task automatic wait_done(input string name, input int budget, input bit toggle);
        int d0;
        int k;
        d0 = n_done;
        k = 0;
        while (n_done == d0 && k < budget) begin
            if (toggle) in_valid = ~in_valid;
            step();
            k++;
        end
        if (n_done == d0) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int d0;
        #2 rst_n = 1'b0;
        step();
        chk("async_rst_we", int'(bram_we), 0);
        step();
        rst_n = 1'b1;
        step();

        // 1: basic job
        wlog.delete();
        in_valid = 1'b1;
        start_job(0, 24, 1, 16, 2, 4'hF);
        wait_done("t1", 100, 1'b0);
        in_valid = 1'b0;
        chk("t1_count", wlog.size(), 32);
        chk("t1_w0", wget(0), 0);
        chk("t1_w15", wget(15), 360);
        chk("t1_w16", wget(16), 1);
        chk("t1_w31", wget(31), 361);
        chk("t1_done_lat", done_cyc - first_we_cyc, 31);
        chk("t1_err", int'(err), 0);
        repeat (2) step();

        // 2: throttled input
        wlog.delete();
        in_valid = 1'b1;
        start_job(0, 24, 1, 16, 2, 4'hF);
        wait_done("t2", 200, 1'b1);
        in_valid = 1'b0;
        chk("t2_count", wlog.size(), 32);
        chk("t2_w16", wget(16), 1);
        chk("t2_w31", wget(31), 361);
        repeat (2) step();

        // 3: overflow at the depth limit
        wlog.delete();
        in_valid = 1'b1;
        start_job(36860, 1, 0, 8, 1, 4'hF);
        wait_done("t3", 50, 1'b0);
        in_valid = 1'b0;
        chk("t3_count", wlog.size(), 4);
        chk("t3_last", wget(3), 36863);
        chk("t3_err", int'(err), 1);
        repeat (2) step();

        // 4: abort after the 5th beat
        wlog.delete();
        in_valid = 1'b1;
        start_job(0, 24, 1, 16, 2, 4'hF);
        repeat (5) step();
        abort = 1'b1;
        d0 = n_done;
        step();
        abort = 1'b0;
        wait_done("t4", 10, 1'b0);
        in_valid = 1'b0;
        chk("t4_count", wlog.size(), 5);
        chk("t4_w4", wget(4), 96);
        chk("t4_one_done", n_done - d0, 1);
        chk("t4_err", int'(err), 0);
        step();
        chk("t4_idle", int'(busy), 0);
        step();

        // 5: mask and zero rows/tiles
        wlog.delete();
        in_valid = 1'b1;
        start_job(100, 24, 1, 0, 0, 4'b0101);
        wait_done("t5", 10, 1'b0);
        in_valid = 1'b0;
        chk("t5_count", wlog.size(), 1);
        chk("t5_addr", wget(0), 100);
        chk("t5_mask", wmask_last, 5);
        repeat (2) step();

        // 6: reset mid-job, then start ignored during RUN
        in_valid = 1'b1;
        start_job(0, 24, 1, 16, 2, 4'hF);
        repeat (6) step();
        d0 = n_done;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_we", int'(bram_we), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("t6_no_done", n_done - d0, 0);
        wlog.delete();
        start_job(0, 24, 1, 16, 2, 4'hF);
        repeat (4) step();
        cfg_base = 16'd5000;
        cfg_rows = 9'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("t6", 100, 1'b0);
        in_valid = 1'b0;
        chk("t6_count", wlog.size(), 32);
        chk("t6_w31", wget(31), 361);
        chk("t6_err", int'(err), 0);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
